// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard / stall
//               controller: ID/EX hazard sources, wait inputs, and the
//               hold / flush / redirect / status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic        reg1_re_i;
    logic        reg2_re_i;
    logic        ex_load_i;
    logic        ex_rd_we_i;
    logic [4:0]  ex_rd_i;
    logic        ex_busy_i;
    logic        mem_wait_i;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;

    logic [3:0]  hold_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic        bubble_mem_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;
    logic [1:0]  state_o;
    logic        timeout_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    // Pipeline side: presents hazard sources, consumes control decisions
    modport master (
        output reg1_raddr_i, reg2_raddr_i, reg1_re_i, reg2_re_i,
               ex_load_i, ex_rd_we_i, ex_rd_i, ex_busy_i, mem_wait_i,
               ex_jump_i, ex_jump_addr_i,
        input  hold_o, flush_ifid_o, flush_idex_o, bubble_mem_o,
               jump_o, jump_addr_o, state_o, timeout_o,
               stall_cnt_o, flush_cnt_o
    );

    // Controller side
    modport slave (
        input  reg1_raddr_i, reg2_raddr_i, reg1_re_i, reg2_re_i,
               ex_load_i, ex_rd_we_i, ex_rd_i, ex_busy_i, mem_wait_i,
               ex_jump_i, ex_jump_addr_i,
        output hold_o, flush_ifid_o, flush_idex_o, bubble_mem_o,
               jump_o, jump_addr_o, state_o, timeout_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller. Combinationally resolves memory
//               wait, multi-cycle EX, taken jumps and load-use hazards into
//               hold/flush/bubble/redirect controls; tracks wait state with a
//               256-cycle timeout and keeps saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  wire logic  clk_100MHz,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_EX_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_TIMEOUT  = 2'd3;

    localparam logic [7:0]  c_WAIT_LAST = 8'hFF;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    logic        w_load_use;
    logic [3:0]  w_hold;
    logic        w_flush_ifid;
    logic        w_flush_idex;
    logic        w_bubble_mem;
    logic        w_jump;
    logic [31:0] w_jump_addr;
    logic [1:0]  w_next_state;

    logic [1:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // A load in EX whose nonzero destination is read by the instruction in ID
    assign w_load_use = bus.ex_load_i & bus.ex_rd_we_i & (bus.ex_rd_i != 5'd0) &
                        ((bus.reg1_re_i & (bus.reg1_raddr_i == bus.ex_rd_i)) |
                         (bus.reg2_re_i & (bus.reg2_raddr_i == bus.ex_rd_i)));

    // Priority resolution: mem wait > EX busy > jump > load-use > none
    always_comb begin
        w_hold       = 4'b0000;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_bubble_mem = 1'b0;
        w_jump       = 1'b0;
        w_jump_addr  = 32'd0;
        if (bus.mem_wait_i) begin
            w_hold = 4'b1111;
        end else if (bus.ex_busy_i) begin
            // Freeze up to ID/EX; the EX/MEM slot drains as a bubble
            w_hold       = 4'b0111;
            w_bubble_mem = 1'b1;
        end else if (bus.ex_jump_i) begin
            w_jump       = 1'b1;
            w_jump_addr  = bus.ex_jump_addr_i;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (w_load_use) begin
            w_hold       = 4'b0011;
            w_flush_idex = 1'b1;
        end
    end

    // Next wait state; exits to RUN/other wait take precedence over timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (bus.mem_wait_i)     w_next_state = c_ST_MEM_WAIT;
                else if (bus.ex_busy_i) w_next_state = c_ST_EX_WAIT;
            end
            c_ST_MEM_WAIT: begin
                if (!bus.mem_wait_i)                w_next_state = bus.ex_busy_i ? c_ST_EX_WAIT : c_ST_RUN;
                else if (r_wait_cnt == c_WAIT_LAST) w_next_state = c_ST_TIMEOUT;
            end
            c_ST_EX_WAIT: begin
                if (bus.mem_wait_i)                 w_next_state = c_ST_MEM_WAIT;
                else if (!bus.ex_busy_i)            w_next_state = c_ST_RUN;
                else if (r_wait_cnt == c_WAIT_LAST) w_next_state = c_ST_TIMEOUT;
            end
            default: begin
                if (!bus.mem_wait_i && !bus.ex_busy_i) w_next_state = c_ST_RUN;
            end
        endcase
    end

    // State, dwell counter and sticky timeout flag
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_wait_cnt <= 8'd0;
            else if (r_state == c_ST_MEM_WAIT || r_state == c_ST_EX_WAIT)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_next_state == c_ST_TIMEOUT && r_state != c_ST_TIMEOUT)
                r_timeout <= 1'b1;
        end
    end

    // Saturating performance counters for PC stalls and flushes
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_hold[0] && r_stall_cnt != c_CNT_MAX)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if ((w_flush_ifid || w_flush_idex) && r_flush_cnt != c_CNT_MAX)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bus.hold_o       = w_hold;
    assign bus.flush_ifid_o = w_flush_ifid;
    assign bus.flush_idex_o = w_flush_idex;
    assign bus.bubble_mem_o = w_bubble_mem;
    assign bus.jump_o       = w_jump;
    assign bus.jump_addr_o  = w_jump_addr;
    assign bus.state_o      = r_state;
    assign bus.timeout_o    = r_timeout;
    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.flush_cnt_o  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. A driver applies directed
//               and random stimulus and pushes the reference model's expected
//               outputs into a queue; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    typedef struct packed {
        logic        rst;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        re1;
        logic        re2;
        logic        ld;
        logic        we;
        logic [4:0]  rd;
        logic        busy;
        logic        mw;
        logic        jmp;
        logic [31:0] ja;
    } stim_t;

    // {hold, flush_ifid, flush_idex, bubble, jump, jump_addr, state, timeout, stall, flush}
    typedef logic [74:0] obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    obs_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cycle  = 0;

    // Reference model state, in terms of named wait phases and elapsed cycles
    int    m_state;      // 0 RUN, 1 MEM_WAIT, 2 EX_WAIT, 3 TIMEOUT
    int    m_cycles;     // 1-based index of the current cycle within the state
    bit    m_timeout;
    int    m_stall;
    int    m_flush;
    stim_t m_prev;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Expected combinational controls: {hold[3:0], fi, fe, bub, jmp, addr[31:0]}
    function automatic logic [39:0] comb_exp(input stim_t s);
        bit hz;
        hz = s.ld && s.we && (s.rd != 0) &&
             ((s.re1 && s.a1 == s.rd) || (s.re2 && s.a2 == s.rd));
        if (s.mw)        return {4'hF, 4'b0000, 32'd0};
        else if (s.busy) return {4'h7, 4'b0010, 32'd0};
        else if (s.jmp)  return {4'h0, 4'b1101, s.ja};
        else if (hz)     return {4'h3, 4'b0100, 32'd0};
        else             return {4'h0, 4'b0000, 32'd0};
    endfunction

    task automatic enter(input int st);
        m_state  = st;
        m_cycles = 1;
        if (st == 3) m_timeout = 1'b1;
    endtask

    // Advance the model across one rising edge using last cycle's inputs
    task automatic model_edge();
        logic [39:0] c;
        c = comb_exp(m_prev);
        if (m_prev.rst) begin
            m_state = 0; m_cycles = 1; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[36] && m_stall < 65535) m_stall++;
            if ((c[35] || c[34]) && m_flush < 65535) m_flush++;
            case (m_state)
                0: if (m_prev.mw) enter(1); else if (m_prev.busy) enter(2); else m_cycles++;
                1: if (!m_prev.mw) enter(m_prev.busy ? 2 : 0);
                   else if (m_cycles == 256) enter(3);
                   else m_cycles++;
                2: if (m_prev.mw) enter(1);
                   else if (!m_prev.busy) enter(0);
                   else if (m_cycles == 256) enter(3);
                   else m_cycles++;
                default: if (!m_prev.mw && !m_prev.busy) enter(0); else m_cycles++;
            endcase
        end
    endtask

    task automatic step(input stim_t s);
        obs_t e;
        @(posedge clk);
        #2;
        model_edge();
        rst                 = s.rst;
        bus.reg1_raddr_i    = s.a1;
        bus.reg2_raddr_i    = s.a2;
        bus.reg1_re_i       = s.re1;
        bus.reg2_re_i       = s.re2;
        bus.ex_load_i       = s.ld;
        bus.ex_rd_we_i      = s.we;
        bus.ex_rd_i         = s.rd;
        bus.ex_busy_i       = s.busy;
        bus.mem_wait_i      = s.mw;
        bus.ex_jump_i       = s.jmp;
        bus.ex_jump_addr_i  = s.ja;
        e = {comb_exp(s), m_state[1:0], m_timeout, m_stall[15:0], m_flush[15:0]};
        q_exp.push_back(e);
        m_prev = s;
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rst  = ($urandom_range(0, 199) == 0);
        s.a1   = 5'($urandom_range(0, 3));
        s.a2   = 5'($urandom_range(0, 3));
        s.re1  = 1'($urandom_range(0, 1));
        s.re2  = 1'($urandom_range(0, 1));
        s.ld   = ($urandom_range(0, 2) != 0);
        s.we   = ($urandom_range(0, 3) != 0);
        s.rd   = 5'($urandom_range(0, 3));
        s.busy = ($urandom_range(0, 6) == 0);
        s.mw   = ($urandom_range(0, 9) == 0);
        s.jmp  = ($urandom_range(0, 4) == 0);
        s.ja   = $urandom;
        return s;
    endfunction

    // Monitor: compares every observed cycle against the queued expectation
    initial begin
        obs_t act;
        obs_t exp;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                exp = q_exp.pop_front();
                act = {bus.hold_o, bus.flush_ifid_o, bus.flush_idex_o, bus.bubble_mem_o,
                       bus.jump_o, bus.jump_addr_o, bus.state_o, bus.timeout_o,
                       bus.stall_cnt_o, bus.flush_cnt_o};
                n_checks++;
                n_cycle++;
                if (act !== exp) begin
                    n_errors++;
                    $display("FAIL ctrl_outputs cycle %0d: actual hold=%h fi=%b fe=%b bub=%b jmp=%b addr=%h st=%0d to=%b stall=%h flush=%h, required hold=%h fi=%b fe=%b bub=%b jmp=%b addr=%h st=%0d to=%b stall=%h flush=%h",
                             n_cycle,
                             act[74:71], act[70], act[69], act[68], act[67], act[66:35], act[34:33], act[32], act[31:16], act[15:0],
                             exp[74:71], exp[70], exp[69], exp[68], exp[67], exp[66:35], exp[34:33], exp[32], exp[31:16], exp[15:0]);
                end
            end
        end
    end

    // Watchdog: the run must never hang
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end, checks=%0d", n_checks);
        $fatal(1);
    end

    // Driver
    initial begin
        stim_t s;
        int    guard;
        rst = 1'b1;
        bus.reg1_raddr_i = '0; bus.reg2_raddr_i = '0; bus.reg1_re_i = 1'b0; bus.reg2_re_i = 1'b0;
        bus.ex_load_i = 1'b0; bus.ex_rd_we_i = 1'b0; bus.ex_rd_i = '0; bus.ex_busy_i = 1'b0;
        bus.mem_wait_i = 1'b0; bus.ex_jump_i = 1'b0; bus.ex_jump_addr_i = '0;
        m_prev = idle(); m_prev.rst = 1'b1;
        m_state = 0; m_cycles = 1; m_timeout = 1'b0; m_stall = 0; m_flush = 0;

        // Reset
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        step(idle());

        // Load-use on rs2, then the same with rd = x0
        s = idle(); s.ld = 1'b1; s.we = 1'b1; s.rd = 5'd5; s.re2 = 1'b1; s.a2 = 5'd5;
        step(s);
        s.rd = 5'd0;
        step(s);
        step(idle());

        // Jump outranks a simultaneous load-use hazard
        s = idle(); s.ld = 1'b1; s.we = 1'b1; s.rd = 5'd5; s.re2 = 1'b1; s.a2 = 5'd5;
        s.jmp = 1'b1; s.ja = 32'h0000_0100;
        step(s);
        step(idle());

        // Mem wait with EX busy, then EX busy alone, then release
        s = idle(); s.mw = 1'b1; s.busy = 1'b1;
        repeat (3) step(s);
        s.mw = 1'b0;
        repeat (2) step(s);
        repeat (2) step(idle());

        // Random mix
        repeat (2000) step(rnd_stim());

        // Clean reset, then a long EX busy to reach the timeout
        s = idle(); s.rst = 1'b1;
        step(s);
        s = idle(); s.busy = 1'b1;
        repeat (300) step(s);
        repeat (3) step(idle());

        // Long mem wait saturates the stall counter; reset pulse mid-wait
        s = idle(); s.mw = 1'b1;
        repeat (70000) step(s);
        s.rst = 1'b1;
        step(s);
        s.rst = 1'b0;
        repeat (3) step(s);
        repeat (2) step(idle());

        guard = 0;
        while (q_exp.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q_exp.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations never observed, required 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk_100MHz, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports reg1_raddr_i / reg2_raddr_i, input, 5 each, ID-stage source register addresses.
REQ-004 SHALL have ports reg1_re_i / reg2_re_i, input, 1 each, ID-stage source-read enables.
REQ-005 SHALL have ports ex_load_i, ex_rd_we_i, input, 1 each, EX-stage instruction is a load / writes rd.
REQ-006 SHALL have port ex_rd_i, input, 5, EX-stage destination register.
REQ-007 SHALL have port ex_busy_i, input, 1, multi-cycle EX operation not finished.
REQ-008 SHALL have port mem_wait_i, input, 1, data memory not ready.
REQ-009 SHALL have ports ex_jump_i (1) and ex_jump_addr_i (32), input, taken branch/jump resolved in EX and its target.
REQ-010 SHALL have port hold_o, output, 4: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM register hold.
REQ-011 SHALL have ports flush_ifid_o, flush_idex_o, bubble_mem_o, output, 1 each, insert NOP into that pipeline register.
REQ-012 SHALL have ports jump_o (1) and jump_addr_o (32), output, PC redirect.
REQ-013 SHALL have ports state_o (2), timeout_o (1), stall_cnt_o (16), flush_cnt_o (16), output, status and performance counters.

Function
REQ-014 SHALL compute hold_o, flush_*, bubble_mem_o, jump_o, jump_addr_o combinationally from current inputs, with strict priority: mem wait > EX busy > jump > load-use > none.
REQ-015 SHALL, when mem_wait_i=1, drive hold_o=4'b1111, all flush/bubble/jump outputs 0.
REQ-016 SHALL, when ex_busy_i=1 and mem_wait_i=0, drive hold_o=4'b0111 and bubble_mem_o=1.
REQ-017 SHALL, when ex_jump_i=1 and no wait, drive jump_o=1, jump_addr_o=ex_jump_addr_i, flush_ifid_o=1, flush_idex_o=1, hold_o=0.
REQ-018 SHALL detect load-use hazard = ex_load_i & ex_rd_we_i & (ex_rd_i!=0) & ((reg1_re_i & reg1_raddr_i==ex_rd_i) | (reg2_re_i & reg2_raddr_i==ex_rd_i)).
REQ-019 SHALL, on load-use hazard with no higher-priority event, drive hold_o=4'b0011 and flush_idex_o=1 for that cycle only.
REQ-020 SHALL drive jump_addr_o=0 whenever jump_o=0.
REQ-021 SHALL implement state register with encodings RUN=0, MEM_WAIT=1, EX_WAIT=2, TIMEOUT=3, output on state_o.
REQ-022 SHALL transition RUN->MEM_WAIT if mem_wait_i; RUN->EX_WAIT if ex_busy_i & !mem_wait_i; else stay RUN.
REQ-023 SHALL transition MEM_WAIT->EX_WAIT if !mem_wait_i & ex_busy_i; MEM_WAIT->RUN if both low.
REQ-024 SHALL transition EX_WAIT->MEM_WAIT if mem_wait_i; EX_WAIT->RUN if both low.
REQ-025 SHALL keep 8-bit wait_cnt: cleared on every state change, incremented each cycle in MEM_WAIT/EX_WAIT without state change.
REQ-026 SHALL transition to TIMEOUT instead of self-looping when wait_cnt==8'hFF and the state's wait input is still 1 (i.e. 256th cycle in the state); REQ-023/024 exits take precedence.
REQ-027 SHALL leave TIMEOUT to RUN only when mem_wait_i=0 and ex_busy_i=0; hold/flush outputs keep following REQ-014 in TIMEOUT.
REQ-028 SHALL set timeout_o=1 on entry to TIMEOUT and keep it sticky until reset.
REQ-029 SHALL increment stall_cnt_o each cycle hold_o[0]=1, saturating at 16'hFFFF.
REQ-030 SHALL increment flush_cnt_o each cycle flush_ifid_o|flush_idex_o=1, saturating at 16'hFFFF.

Reset
REQ-031 SHALL, on clock edge with rst=1, set state RUN, wait_cnt=0, timeout_o=0, stall_cnt_o=0, flush_cnt_o=0, overriding all other updates.
REQ-032 SHALL keep combinational outputs input-driven during reset; counters do not count on reset edge.

Verification
REQ-033 ex_load_i=1, ex_rd_we_i=1, ex_rd_i=5, reg2_re_i=1, reg2_raddr_i=5 -> hold_o=4'b0011, flush_idex_o=1, stall_cnt_o +1; same with ex_rd_i=0 -> hold_o=0.
REQ-034 ex_jump_i=1, ex_jump_addr_i=32'h0000_0100 plus load-use hazard -> jump_o=1, jump_addr_o=32'h100, flush_ifid_o=flush_idex_o=1, hold_o=0, flush_cnt_o +1.
REQ-035 mem_wait_i=1 and ex_busy_i=1 for 3 cycles, then mem_wait_i=0 for 2 cycles -> hold_o=4'b1111, state_o=1 then hold_o=4'b0111, bubble_mem_o=1, state_o=2, then RUN.
REQ-036 ex_busy_i=1 for 300 cycles -> state_o=3 and timeout_o=1 after 256 cycles in EX_WAIT; ex_busy_i=0 -> state_o=0, timeout_o stays 1.
REQ-037 mem_wait_i=1 for 70000 cycles -> stall_cnt_o saturates at 16'hFFFF; rst=1 one cycle mid-wait -> all counters 0, state RUN, then MEM_WAIT next edge.
